// File: rtl/bp_tag_master_pkg.sv
// Packet field widths, command-table entry and FSM state for the tag master.
package bp_tag_master_pkg;

    // Field widths of one tag packet as stored in the command table.
    localparam int tag_len_width_gp     = 4;
    localparam int tag_node_id_width_gp = 4;
    localparam int tag_payload_width_gp = 16;
    localparam int tag_num_cmds_gp      = 7;

    typedef logic [tag_len_width_gp-1:0]     tag_len_t;
    typedef logic [tag_node_id_width_gp-1:0] tag_node_id_t;
    typedef logic [tag_payload_width_gp-1:0] tag_payload_t;

    // One command-table entry: which client, reset or data, and what to send.
    typedef struct packed {
        tag_node_id_t node_id;
        logic         data_not_reset;
        tag_len_t     len;
        tag_payload_t payload;
    } tag_cmd_s;

    // Master sequencing states; LOAD is the cycle that emits the start bit of a packet.
    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_load  = 2'd1,
        e_shift = 2'd2,
        e_done  = 2'd3
    } tag_state_e;

    // Keep only the low 'width' bits of a payload value.
    function automatic tag_payload_t fit_payload(input int value, input int width);
        int mask;
        mask = (1 << width) - 1;
        return tag_payload_t'(value & mask);
    endfunction

    // Build one command-table entry from plain integers.
    function automatic tag_cmd_s make_cmd(input int node, input logic dnr,
                                          input int width, input int value);
        tag_cmd_s c;
        c.node_id        = tag_node_id_t'(node);
        c.data_not_reset = dnr;
        c.len            = tag_len_t'(width);
        c.payload        = fit_payload(value, width);
        return c;
    endfunction

endpackage

// File: rtl/bsg_tag_pkg.sv
// Tag bus definitions shared by every tag master and tag client.
package bsg_tag_pkg;

    // One client's view of the tag bus: clock, serial data, parameter select, enable.
    typedef struct packed {
        logic clk;
        logic op;
        logic param;
        logic en;
    } bsg_tag_s;

endpackage

// File: rtl/bp_tag_packet_serializer.sv
// Turns one command-table entry into the serial tag bit stream, one bit per cycle.
// Bit 0 is the start bit, then node_id and len MSB first, then payload LSB first.
// done_o marks the cycle carrying the last bit, so the next entry can start
// on the following cycle without a gap.
module bp_tag_packet_serializer
    import bp_tag_master_pkg::*;
#(
    parameter int lg_width_p      = 4,
    parameter int node_id_width_p = 2
) (
    input  logic     clk_i,
    input  logic     reset_i,
    input  logic     active_i,
    input  tag_cmd_s cmd_i,
    output logic     bit_o,
    output logic     done_o
);

    localparam int hdr_bits_lp = 2 + node_id_width_p + lg_width_p;

    logic [7:0]             idx_q, idx_d;
    logic [7:0]             total_bits;
    logic [hdr_bits_lp-1:0] hdr, hdr_shift;
    tag_payload_t           pay_shift;

    assign hdr = {1'b1, cmd_i.node_id[node_id_width_p-1:0], cmd_i.data_not_reset,
                  cmd_i.len[lg_width_p-1:0]};
    assign total_bits = 8'(hdr_bits_lp) + 8'(cmd_i.len);
    assign done_o     = active_i && (idx_q == total_bits - 8'd1);

    // Select the current bit: header bits MSB first, then payload LSB first.
    always_comb begin
        hdr_shift = hdr << idx_q;
        pay_shift = cmd_i.payload >> (idx_q - 8'(hdr_bits_lp));
        bit_o     = 1'b0;
        if (idx_q < 8'(hdr_bits_lp)) begin
            bit_o = hdr_shift[hdr_bits_lp-1];
        end else begin
            bit_o = pay_shift[0];
        end
    end

    // Bit index advances while active and wraps to 0 after the last bit.
    always_comb begin
        idx_d = idx_q + 8'd1;
        if (!active_i || done_o) begin
            idx_d = '0;
        end
    end

    // Bit index register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/bp_tag_master.sv
// Tag master: after a quiet period, programs tile reset and tile X/Y
// coordinates into three tag clients over one shared serial line,
// then raises tag_done_o until the next reset.
module bp_tag_master
    import bp_tag_master_pkg::*;
    import bsg_tag_pkg::*;
#(
    parameter int els_p          = 3,
    parameter int lg_width_p     = 4,
    parameter int x_cord_width_p = 7,
    parameter int y_cord_width_p = 7,
    parameter int x_cord_p       = 0,
    parameter int y_cord_p       = 1,
    parameter int idle_cycles_p  = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    output bsg_tag_s [els_p-1:0] bsg_tag_o,
    output logic                 tag_done_o
);

    localparam int node_id_width_lp = $clog2(els_p);

    tag_state_e  state_q, state_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic [2:0]  cmd_idx_q, cmd_idx_d;
    tag_cmd_s    cmd;
    logic        active, ser_bit, ser_done, op;

    // Command table: reset packets to every client, then data, then release tile reset.
    always_comb begin
        cmd = '0;
        case (cmd_idx_q)
            3'd0:    cmd = make_cmd(0, 1'b0, 1,              -1);
            3'd1:    cmd = make_cmd(1, 1'b0, x_cord_width_p, -1);
            3'd2:    cmd = make_cmd(2, 1'b0, y_cord_width_p, -1);
            3'd3:    cmd = make_cmd(0, 1'b1, 1,              1);
            3'd4:    cmd = make_cmd(1, 1'b1, x_cord_width_p, x_cord_p);
            3'd5:    cmd = make_cmd(2, 1'b1, y_cord_width_p, y_cord_p);
            3'd6:    cmd = make_cmd(0, 1'b1, 1,              0);
            default: cmd = '0;
        endcase
    end

    assign active = (state_q == e_load) || (state_q == e_shift);
    assign op     = active & ser_bit;

    bp_tag_packet_serializer #(
        .lg_width_p     (lg_width_p),
        .node_id_width_p(node_id_width_lp)
    ) u_serializer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .active_i(active),
        .cmd_i   (cmd),
        .bit_o   (ser_bit),
        .done_o  (ser_done)
    );

    // Next state: count the quiet period, then stream packets back to back.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        cmd_idx_d  = cmd_idx_q;
        case (state_q)
            e_idle: begin
                idle_cnt_d = idle_cnt_q + 16'd1;
                if (idle_cnt_q == 16'(idle_cycles_p - 1)) begin
                    state_d = e_load;
                end
            end
            e_load, e_shift: begin
                state_d = e_shift;
                if (ser_done) begin
                    if (cmd_idx_q == 3'(tag_num_cmds_gp - 1)) begin
                        state_d = e_done;
                    end else begin
                        cmd_idx_d = cmd_idx_q + 3'd1;
                        state_d   = e_load;
                    end
                end
            end
            e_done:  state_d = e_done;
            default: state_d = e_idle;
        endcase
    end

    // State, idle counter and command index registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= e_idle;
            idle_cnt_q <= '0;
            cmd_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            cmd_idx_q  <= cmd_idx_d;
        end
    end

    assign tag_done_o = (state_q == e_done);

    // Every client sees the same clock, the same serial line, param 0 and enable 1.
    for (genvar i = 0; i < els_p; i++) begin : g_tag
        assign bsg_tag_o[i] = '{clk: clk_i, op: op, param: 1'b0, en: 1'b1};
    end

endmodule

// File: tb/tb_bp_tag_master.sv
// Bench for bp_tag_master: three instances (default coordinates, X=5/Y=3,
// oversized coordinates) run from one clock and one reset.
module tb_bp_tag_master;
    import bsg_tag_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    bsg_tag_s [2:0] tag_a, tag_b, tag_c;
    logic           done_a, done_b, done_c;

    bp_tag_master dut_a (.clk_i(clk), .reset_i(rst), .bsg_tag_o(tag_a), .tag_done_o(done_a));
    bp_tag_master #(.x_cord_p(5), .y_cord_p(3)) dut_b (
        .clk_i(clk), .reset_i(rst), .bsg_tag_o(tag_b), .tag_done_o(done_b));
    bp_tag_master #(.x_cord_p(200), .y_cord_p(300)) dut_c (
        .clk_i(clk), .reset_i(rst), .bsg_tag_o(tag_c), .tag_done_o(done_c));

    int checks = 0;
    int errors = 0;

    logic build_q[$];
    logic exp_a_q[$], exp_b_q[$], exp_c_q[$];
    logic obs_a_q[$], obs_b_q[$];
    logic dec_q[$];
    int   dpos;

    // Reference model: expected op per cycle after reset release (idle zeros then packets).
    function automatic void push_bits(input int val, input int w, input bit msb_first);
        for (int k = 0; k < w; k++) begin
            if (msb_first) build_q.push_back(1'((val >> (w - 1 - k)) & 1));
            else           build_q.push_back(1'((val >> k) & 1));
        end
    endfunction

    function automatic void build_model(input int x, input int y);
        int lens[3]  = '{1, 7, 7};
        int nodes[7] = '{0, 1, 2, 0, 1, 2, 0};
        int dnr[7]   = '{0, 0, 0, 1, 1, 1, 1};
        int pay[7];
        pay = '{1, 127, 127, 1, x % 128, y % 128, 0};
        build_q.delete();
        for (int k = 0; k < 8; k++) build_q.push_back(1'b0);
        for (int p = 0; p < 7; p++) begin
            build_q.push_back(1'b1);
            push_bits(nodes[p], 2, 1'b1);
            push_bits(dnr[p], 1, 1'b1);
            push_bits(lens[nodes[p]], 4, 1'b1);
            push_bits(pay[p], lens[nodes[p]], 1'b0);
        end
    endfunction

    function automatic logic exp_op(input int d, input int c);
        case (d)
            0: return (c < exp_a_q.size()) ? exp_a_q[c] : 1'b0;
            1: return (c < exp_b_q.size()) ? exp_b_q[c] : 1'b0;
            default: return (c < exp_c_q.size()) ? exp_c_q[c] : 1'b0;
        endcase
    endfunction

    function automatic logic exp_done(input int d, input int c);
        case (d)
            0: return c >= exp_a_q.size();
            1: return c >= exp_b_q.size();
            default: return c >= exp_c_q.size();
        endcase
    endfunction

    function automatic int rd_bits(input int w, input bit msb_first);
        int   v = 0;
        logic b;
        for (int k = 0; k < w; k++) begin
            b = (dpos < dec_q.size()) ? dec_q[dpos] : 1'b0;
            dpos++;
            if (msb_first) v = (v << 1) | int'(b);
            else           v = v | (int'(b) << k);
        end
        return v;
    endfunction

    task automatic test_reset_hold();
        rst = 1'b0;
        #2 rst = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (tag_a[i].clk !== 1'b1 || tag_b[i].clk !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_clk_high cycle %0d client %0d: got %b/%b expected 1", c, i, tag_a[i].clk, tag_b[i].clk);
                end
                checks++;
                if (tag_a[i].op !== 1'b0 || tag_b[i].op !== 1'b0 || tag_c[i].op !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_op cycle %0d client %0d: got %b%b%b expected 000", c, i, tag_a[i].op, tag_b[i].op, tag_c[i].op);
                end
                checks++;
                if (tag_a[i].param !== 1'b0 || tag_a[i].en !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_param_en client %0d: got param %b en %b expected 0 1", i, tag_a[i].param, tag_a[i].en);
                end
            end
            checks++;
            if (done_a !== 1'b0 || done_b !== 1'b0 || done_c !== 1'b0) begin
                errors++;
                $display("FAIL reset_done cycle %0d: got %b%b%b expected 000", c, done_a, done_b, done_c);
            end
            @(negedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (tag_a[i].clk !== 1'b0 || tag_c[i].clk !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_clk_low cycle %0d client %0d: got %b/%b expected 0", c, i, tag_a[i].clk, tag_c[i].clk);
                end
            end
        end
    endtask

    // Caller releases reset at a falling edge; cycle c is sampled after c rising edges.
    task automatic run_and_check(input int ncycles, input bit check_done_edge);
        int first_done = -1;
        obs_a_q.delete();
        obs_b_q.delete();
        for (int c = 0; c < ncycles; c++) begin
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (tag_a[i].op !== exp_op(0, c)) begin
                    errors++;
                    $display("FAIL op_a cycle %0d client %0d: got %b expected %b", c, i, tag_a[i].op, exp_op(0, c));
                end
                checks++;
                if (tag_b[i].op !== exp_op(1, c)) begin
                    errors++;
                    $display("FAIL op_b cycle %0d client %0d: got %b expected %b", c, i, tag_b[i].op, exp_op(1, c));
                end
                checks++;
                if (tag_c[i].op !== exp_op(2, c)) begin
                    errors++;
                    $display("FAIL op_c cycle %0d client %0d: got %b expected %b", c, i, tag_c[i].op, exp_op(2, c));
                end
            end
            checks++;
            if (done_a !== exp_done(0, c) || done_b !== exp_done(1, c) || done_c !== exp_done(2, c)) begin
                errors++;
                $display("FAIL done cycle %0d: got %b%b%b expected %b%b%b", c, done_a, done_b, done_c,
                         exp_done(0, c), exp_done(1, c), exp_done(2, c));
            end
            if (c >= 8 && c < exp_a_q.size()) begin
                obs_a_q.push_back(tag_a[0].op);
                obs_b_q.push_back(tag_b[1].op);
            end
            if (done_a === 1'b1 && first_done < 0) first_done = c;
            @(negedge clk);
        end
        if (check_done_edge) begin
            checks++;
            if (first_done != 95) begin
                errors++;
                $display("FAIL done_edge: got %0d expected 95", first_done);
            end
        end
    endtask

    task automatic decode_check(input string name, input int x, input int y);
        int exp_node[7] = '{0, 1, 2, 0, 1, 2, 0};
        int exp_dnr[7]  = '{0, 0, 0, 1, 1, 1, 1};
        int exp_len[7]  = '{1, 7, 7, 1, 7, 7, 1};
        int exp_pay[7];
        int st, node, dnr, len, pay;
        exp_pay = '{1, 127, 127, 1, x % 128, y % 128, 0};
        dpos = 0;
        for (int p = 0; p < 7; p++) begin
            st   = rd_bits(1, 1'b1);
            node = rd_bits(2, 1'b1);
            dnr  = rd_bits(1, 1'b1);
            len  = rd_bits(4, 1'b1);
            pay  = rd_bits(len, 1'b0);
            checks++;
            if (st != 1 || node != exp_node[p] || dnr != exp_dnr[p]) begin
                errors++;
                $display("FAIL %s pkt%0d header: got start %0d node %0d dnr %0d expected 1 %0d %0d",
                         name, p, st, node, dnr, exp_node[p], exp_dnr[p]);
            end
            checks++;
            if (len != exp_len[p] || pay != exp_pay[p]) begin
                errors++;
                $display("FAIL %s pkt%0d body: got len %0d payload %0d expected %0d %0d",
                         name, p, len, pay, exp_len[p], exp_pay[p]);
            end
        end
        checks++;
        if (dpos != dec_q.size()) begin
            errors++;
            $display("FAIL %s stream_len: got %0d expected %0d", name, dec_q.size(), dpos);
        end
    endtask

    task automatic test_sequence();
        @(negedge clk);
        rst = 1'b0;
        run_and_check(100, 1'b1);
        dec_q = obs_a_q;
        decode_check("decode_a", 0, 1);
        dec_q = obs_b_q;
        decode_check("decode_b", 5, 3);
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_and_check(40, 1'b0);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (tag_a[0].op !== 1'b0 || tag_b[1].op !== 1'b0 || tag_c[2].op !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_op: got %b%b%b expected 000", tag_a[0].op, tag_b[1].op, tag_c[2].op);
        end
        checks++;
        if (done_a !== 1'b0 || done_b !== 1'b0 || done_c !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_done: got %b%b%b expected 000", done_a, done_b, done_c);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run_and_check(100, 1'b1);
        dec_q = obs_a_q;
        decode_check("restart_a", 0, 1);
    endtask

    initial begin
        build_model(0, 1);
        exp_a_q = build_q;
        build_model(5, 3);
        exp_b_q = build_q;
        build_model(200, 300);
        exp_c_q = build_q;
        test_reset_hold();
        test_sequence();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
